cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Arbitrates the single common data bus (CDB) among the functional units that sit behind the reservation stations. Each FU result is captured in a one-entry holding slot. Each cycle at most one slot is granted, round-robin, and broadcast on a registered CDB output. Reservation stations snoop that output for operand tags and for their own completion tag.

Parameters:
NUM_FU, 4, number of FU result ports (2..8)
PTR_W, $clog2(NUM_FU), width of round-robin pointer (derived, not overridden)

Ports:
clk_i  input  1  clock, all state on rising edge
reset_ni  input  1  asynchronous active-low reset
fu_valid_i  input  NUM_FU  FU i presents a result this cycle
fu_tag_i  input  NUM_FU x rs_tag_t  producing RS tag per FU
fu_val_i  input  NUM_FU x word32_t  result value per FU
fu_ready_o  output  NUM_FU  slot i can accept a result this cycle
cdb_o  output  cdb_t  registered broadcast {tag, val}; tag NO_VAL when idle
grant_o  output  NUM_FU  one-hot slot granted this cycle (combinational, zero when none)
pending_o  output  PTR_W+1  count of full slots

Behaviour:
- Reset (async assert, sync-safe deassert): all slots empty; rr_ptr=0; cdb_o.tag=NO_VAL; cdb_o.val=0; fu_ready_o all 1; grant_o=0; pending_o=0. Reset mid-operation drops every held result with no broadcast.
- Slot i state: full bit, tag, val.
- Accept: handshake when fu_valid_i[i] & fu_ready_o[i]. Slot loads fu_tag_i/fu_val_i and sets full at the edge.
- fu_ready_o[i] = ~full[i] | grant_o[i]. A slot granted this cycle accepts a new result at the same edge, so it stays full.
- fu_valid_i[i] with fu_ready_o[i]=0: no capture. The FU holds valid/tag/val stable until ready.
- fu_valid_i[i] with fu_tag_i[i]=NO_VAL: ignored, treated as not valid.
- Arbitration is combinational over full[] only. A result arriving this cycle is not eligible until the next cycle.
  - Search order: rr_ptr, rr_ptr+1, ... mod NUM_FU. The first full slot wins; grant_o is one-hot.
  - On grant k: cdb_o <= {slot k tag, slot k val} at the edge; full[k] cleared unless refilled by a same-cycle accept; rr_ptr <= (k+1) mod NUM_FU.
  - No full slot: cdb_o.tag <= NO_VAL, cdb_o.val <= 0, rr_ptr unchanged.
- Latency: accept at edge E0 gives a broadcast visible from E1 through E2, for exactly one cycle. The minimum FU-to-CDB latency is 1 cycle after capture.
- Fairness: a full slot waits at most NUM_FU-1 grants.
- Throughput: one broadcast per cycle while pending_o>0.
- pending_o = popcount(full), registered-state based.
- Simultaneous grant and accept on the same slot: the broadcast carries the old content and the slot holds the new one. No loss, no duplicate.
- Every tag value appears on cdb_o for exactly one cycle per accepted result. Reservation stations depend on this to leave WAIT_4_FIN.
- No tag uniqueness check. Tags are unique because each RS owns exactly one FU.

Decomposition:
- data_types package (existing): rs_tag_t, NO_VAL, word32_t, cdb_t. Add fu_result_t {rs_tag_t tag; word32_t val;} for slot storage. Add constant NUM_FU_DEFAULT=4.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx, any_gnt.
  - Purely combinational, double-width mask-and-priority scheme.
  - The pointer register stays in cdb_arbiter.

Test Plan:
- Reset: hold reset_ni=0 with fu_valid_i=4'b1111 -> cdb_o.tag=NO_VAL, val=0, fu_ready_o=4'b1111, pending_o=0. Deassert with inputs idle -> CDB stays idle.
- Single result: FU2 drives tag ALU_1, val 32'hDEAD_BEEF for one cycle -> cdb_o={ALU_1,32'hDEADBEEF} exactly one cycle, starting one cycle after capture, then NO_VAL. grant_o=4'b0100 in the cycle before.
- All four FUs valid in the same cycle, rr_ptr=0 -> broadcasts in order FU0,FU1,FU2,FU3 on 4 consecutive cycles; pending_o 4,3,2,1,0.
- Round-robin rotation: after FU1 wins, FU0 and FU1 both refill -> FU0 waits behind no one else but is served next; FU1 is not served twice consecutively while FU0 is full.
- Back-pressure and refill: FU3 slot full and not granted -> fu_ready_o[3]=0, new value held by FU3 is not lost. In the cycle slot 3 is granted, ready=1; the new value is captured and broadcast on a later grant, giving both values once each in order.
- Async reset mid-stream: assert reset_ni=0 between edges with 3 slots full -> outputs reach reset values immediately without a clock edge; no held tag is broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: RS tags, data words, CDB beat, FU slot.
package cdb_arbiter_pkg;

  typedef logic [2:0]  rs_tag_t;
  typedef logic [31:0] word32_t;

  // Reservation-station tags; NO_VAL marks an idle bus or an absent result.
  localparam rs_tag_t NO_VAL = 3'd0;
  localparam rs_tag_t ALU_1  = 3'd1;
  localparam rs_tag_t ALU_2  = 3'd2;
  localparam rs_tag_t MUL_1  = 3'd3;
  localparam rs_tag_t MUL_2  = 3'd4;
  localparam rs_tag_t LD_1   = 3'd5;
  localparam rs_tag_t LD_2   = 3'd6;
  localparam rs_tag_t ST_1   = 3'd7;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } fu_result_t;

  localparam int unsigned NUM_FU_DEFAULT = 4;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] gnt_idx_o,
  output logic            any_gnt_o
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] masked;

  // Upper copy of req keeps every request reachable, so the wrap-around needs no second pass.
  always_comb begin
    req_dbl = {req_i, req_i};
    for (int i = 0; i < 2 * int'(N); i++) begin
      masked[i] = req_dbl[i] && (i >= int'(ptr_i));
    end
  end

  // Lowest set bit of the masked vector, folded back into the 0..N-1 range.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int i = 0; i < 2 * int'(N); i++) begin
      if (!any_gnt_o && masked[i]) begin
        any_gnt_o = 1'b1;
        if (i >= int'(N)) begin
          gnt_idx_o = PtrW'(i - int'(N));
        end else begin
          gnt_idx_o = PtrW'(i);
        end
      end
    end
    if (any_gnt_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, round-robin grant, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_FU = NUM_FU_DEFAULT,
  localparam int unsigned PTR_W  = $clog2(NUM_FU)
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NUM_FU-1:0]   fu_valid_i,
  input  rs_tag_t             fu_tag_i [NUM_FU],
  input  word32_t             fu_val_i [NUM_FU],
  output logic [NUM_FU-1:0]   fu_ready_o,
  output cdb_t                cdb_o,
  output logic [NUM_FU-1:0]   grant_o,
  output logic [PTR_W:0]      pending_o
);

  localparam int unsigned CntW = PTR_W + 1;

  logic [NUM_FU-1:0] full_q, full_d;
  fu_result_t        slot_q [NUM_FU];
  fu_result_t        slot_d [NUM_FU];
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  cdb_t              cdb_d;

  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [NUM_FU-1:0] accept;

  // Only registered full bits compete, so a result captured this edge waits a cycle.
  rr_arbiter #(
    .N (NUM_FU)
  ) u_rr_arbiter (
    .req_i     (full_q),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (grant),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign grant_o = grant;

  // A slot draining this cycle can refill at the same edge; NO_VAL results are dropped.
  always_comb begin
    for (int i = 0; i < int'(NUM_FU); i++) begin
      fu_ready_o[i] = ~full_q[i] | grant[i];
      accept[i]     = fu_valid_i[i] && (fu_tag_i[i] != NO_VAL) && fu_ready_o[i];
    end
  end

  // Slot, pointer and broadcast next state.
  always_comb begin
    full_d   = full_q;
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    cdb_d    = '{tag: NO_VAL, val: '0};
    if (any_gnt) begin
      full_d[gnt_idx] = 1'b0;
      cdb_d.tag       = slot_q[gnt_idx].tag;
      cdb_d.val       = slot_q[gnt_idx].val;
      rr_ptr_d        = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
    // Accept overrides the clear so a granted-and-refilled slot stays full.
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (accept[i]) begin
        full_d[i]     = 1'b1;
        slot_d[i].tag = fu_tag_i[i];
        slot_d[i].val = fu_val_i[i];
      end
    end
  end

  // Number of occupied slots.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      pending_o = pending_o + CntW'(full_q[i]);
    end
  end

  // State registers; reset discards held results without broadcasting them.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      full_q   <= '0;
      rr_ptr_q <= '0;
      cdb_o    <= '{tag: NO_VAL, val: '0};
      for (int i = 0; i < int'(NUM_FU); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      full_q   <= full_d;
      rr_ptr_q <= rr_ptr_d;
      cdb_o    <= cdb_d;
      for (int i = 0; i < int'(NUM_FU); i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [3:0]  fu_valid_i;
  rs_tag_t     fu_tag_i [4];
  word32_t     fu_val_i [4];
  logic [3:0]  fu_ready_o;
  cdb_t        cdb_o;
  logic [3:0]  grant_o;
  logic [2:0]  pending_o;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter #(
    .NUM_FU (4)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .fu_valid_i (fu_valid_i),
    .fu_tag_i   (fu_tag_i),
    .fu_val_i   (fu_val_i),
    .fu_ready_o (fu_ready_o),
    .cdb_o      (cdb_o),
    .grant_o    (grant_o),
    .pending_o  (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_fu(input int i, input rs_tag_t t, input word32_t v);
    fu_valid_i[i] = 1'b1;
    fu_tag_i[i]   = t;
    fu_val_i[i]   = v;
  endtask

  task automatic clr_all();
    fu_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      fu_tag_i[i] = NO_VAL;
      fu_val_i[i] = '0;
    end
  endtask

  task automatic reset_pulse();
    #2 reset_ni = 1'b0;
    step();
    #2 reset_ni = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr_all();
    reset_ni = 1'b0;

    // Reset held with all FUs asserting valid.
    for (int i = 0; i < 4; i++) set_fu(i, rs_tag_t'(i + 1), 32'h1000 + i);
    step();
    step();
    check_eq("rst_cdb", cdb_o, {NO_VAL, 32'h0});
    check_eq("rst_ready", fu_ready_o, 4'b1111);
    check_eq("rst_pending", pending_o, 3'd0);
    check_eq("rst_grant", grant_o, 4'b0000);
    clr_all();
    #2 reset_ni = 1'b1;
    step();
    step();
    check_eq("idle_cdb", cdb_o, {NO_VAL, 32'h0});
    check_eq("idle_pending", pending_o, 3'd0);

    // Single result from FU2.
    set_fu(2, ALU_1, 32'hDEAD_BEEF);
    check_eq("single_ready", fu_ready_o, 4'b1111);
    step();
    clr_all();
    check_eq("single_pending", pending_o, 3'd1);
    check_eq("single_grant", grant_o, 4'b0100);
    check_eq("single_cdb_pre", cdb_o, {NO_VAL, 32'h0});
    step();
    check_eq("single_cdb", cdb_o, {ALU_1, 32'hDEAD_BEEF});
    check_eq("single_pending0", pending_o, 3'd0);
    check_eq("single_grant0", grant_o, 4'b0000);
    step();
    check_eq("single_cdb_post", cdb_o, {NO_VAL, 32'h0});

    // All four at once, pointer back at 0.
    reset_pulse();
    for (int i = 0; i < 4; i++) set_fu(i, rs_tag_t'(i + 1), 32'h100 + i);
    step();
    clr_all();
    check_eq("all_pending4", pending_o, 3'd4);
    check_eq("all_grant0", grant_o, 4'b0001);
    step();
    check_eq("all_cdb0", cdb_o, {ALU_1, 32'h100});
    check_eq("all_pending3", pending_o, 3'd3);
    check_eq("all_grant1", grant_o, 4'b0010);
    step();
    check_eq("all_cdb1", cdb_o, {ALU_2, 32'h101});
    check_eq("all_pending2", pending_o, 3'd2);
    check_eq("all_grant2", grant_o, 4'b0100);
    step();
    check_eq("all_cdb2", cdb_o, {MUL_1, 32'h102});
    check_eq("all_pending1", pending_o, 3'd1);
    check_eq("all_grant3", grant_o, 4'b1000);
    step();
    check_eq("all_cdb3", cdb_o, {MUL_2, 32'h103});
    check_eq("all_pending0", pending_o, 3'd0);
    step();
    check_eq("all_cdb_idle", cdb_o, {NO_VAL, 32'h0});

    // Rotation: FU1 wins, then FU0 and FU1 refill; FU0 must go before FU1 again.
    set_fu(1, ALU_2, 32'hA1);
    step();
    clr_all();
    check_eq("rr_grant1", grant_o, 4'b0010);
    set_fu(0, ALU_1, 32'hB0);
    set_fu(1, ALU_2, 32'hB1);
    check_eq("rr_ready", fu_ready_o, 4'b1111);
    step();
    clr_all();
    check_eq("rr_cdb_a1", cdb_o, {ALU_2, 32'hA1});
    check_eq("rr_pending2", pending_o, 3'd2);
    check_eq("rr_grant_fu0", grant_o, 4'b0001);
    step();
    check_eq("rr_cdb_b0", cdb_o, {ALU_1, 32'hB0});
    check_eq("rr_grant_fu1", grant_o, 4'b0010);
    step();
    check_eq("rr_cdb_b1", cdb_o, {ALU_2, 32'hB1});
    step();
    check_eq("rr_cdb_idle", cdb_o, {NO_VAL, 32'h0});

    // Back-pressure on slot 3 (pointer now 2).
    set_fu(2, MUL_1, 32'hC2);
    set_fu(3, MUL_2, 32'hC3);
    step();
    clr_all();
    set_fu(3, MUL_2, 32'hD3);
    check_eq("bp_grant2", grant_o, 4'b0100);
    check_eq("bp_ready", fu_ready_o, 4'b0111);
    step();
    check_eq("bp_cdb_c2", cdb_o, {MUL_1, 32'hC2});
    check_eq("bp_grant3", grant_o, 4'b1000);
    check_eq("bp_ready3", fu_ready_o, 4'b1111);
    step();
    clr_all();
    check_eq("bp_cdb_c3", cdb_o, {MUL_2, 32'hC3});
    check_eq("bp_pending1", pending_o, 3'd1);
    check_eq("bp_grant3b", grant_o, 4'b1000);
    step();
    check_eq("bp_cdb_d3", cdb_o, {MUL_2, 32'hD3});
    check_eq("bp_pending0", pending_o, 3'd0);
    step();
    check_eq("bp_cdb_idle", cdb_o, {NO_VAL, 32'h0});

    // NO_VAL tag with valid set is ignored.
    set_fu(1, NO_VAL, 32'h55);
    step();
    clr_all();
    check_eq("noval_pending", pending_o, 3'd0);

    // Async reset with three slots full and a live broadcast.
    reset_pulse();
    set_fu(0, ALU_1, 32'hE0);
    set_fu(1, ALU_2, 32'hE1);
    set_fu(2, MUL_1, 32'hE2);
    step();
    clr_all();
    set_fu(0, ALU_1, 32'hF0);
    step();
    clr_all();
    check_eq("ar_cdb_live", cdb_o, {ALU_1, 32'hE0});
    check_eq("ar_pending3", pending_o, 3'd3);
    #2 reset_ni = 1'b0;
    #1;
    check_eq("ar_cdb", cdb_o, {NO_VAL, 32'h0});
    check_eq("ar_pending", pending_o, 3'd0);
    check_eq("ar_ready", fu_ready_o, 4'b1111);
    check_eq("ar_grant", grant_o, 4'b0000);
    step();
    #2 reset_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("ar_post_cdb", cdb_o, {NO_VAL, 32'h0});
    end
    check_eq("ar_post_pending", pending_o, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
